// File: rtl/mac_dispatch_scheduler.sv
// -----------------------------------------------------------------------------
// mac_dispatch_scheduler
//
// Distributes whole packets (one neuron's worth of input/weight beats) across
// C_NUM_MACS downstream MAC lanes in round-robin order. Results are collected
// from the lanes in the same order and returned one beat per packet, tagged
// with the packet's TID.
//
// Ports
//   ACLK, ARESETN        clock, synchronous active-low reset
//   S_AXIS_*             upstream packet stream (TDATA = {input, weight},
//                        TUSER = bias, TID = tag)
//   MAC_SD_*             per-lane operand streams (data fanned out to all,
//                        only the selected lane sees TVALID)
//   MAC_MO_*             per-lane result streams
//   M_AXIS_*             result stream, one beat per packet, TLAST always 1
//   OUTSTANDING          packets dispatched whose result is not yet collected
// -----------------------------------------------------------------------------
module mac_dispatch_scheduler #(
  parameter int C_DATA_WIDTH = 8,
  parameter int C_NUM_MACS   = 4
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  input  logic [2*C_DATA_WIDTH-1:0]           S_AXIS_TDATA,
  input  logic                                S_AXIS_TLAST,
  input  logic [31:0]                         S_AXIS_TUSER,
  input  logic [7:0]                          S_AXIS_TID,
  output logic [C_NUM_MACS-1:0]               MAC_SD_TVALID,
  input  logic [C_NUM_MACS-1:0]               MAC_SD_TREADY,
  output logic [C_NUM_MACS*2*C_DATA_WIDTH-1:0] MAC_SD_TDATA,
  output logic [C_NUM_MACS-1:0]               MAC_SD_TLAST,
  output logic [C_NUM_MACS*32-1:0]            MAC_SD_TUSER,
  input  logic [C_NUM_MACS-1:0]               MAC_MO_TVALID,
  input  logic [C_NUM_MACS*32-1:0]            MAC_MO_TDATA,
  output logic [C_NUM_MACS-1:0]               MAC_MO_TREADY,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic [31:0]                         M_AXIS_TDATA,
  output logic                                M_AXIS_TLAST,
  output logic [7:0]                          M_AXIS_TID,
  output logic [3:0]                          OUTSTANDING
);

  localparam int PW = (C_NUM_MACS > 1) ? $clog2(C_NUM_MACS) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_LANE} state_t;

  state_t                       state_q, state_d;
  logic [PW-1:0]                d_ptr_q, d_ptr_d;
  logic [PW-1:0]                c_ptr_q, c_ptr_d;
  logic [C_NUM_MACS-1:0]        busy_q, busy_d;
  logic                         first_q, first_d;
  logic [C_NUM_MACS-1:0][7:0]   tag_q, tag_d;
  logic                         out_valid_q, out_valid_d;
  logic [31:0]                  out_data_q, out_data_d;
  logic [7:0]                   out_tid_q, out_tid_d;
  logic [3:0]                   outstanding_q, outstanding_d;

  logic s_ready;
  logic dispatch_hs;
  logic dispatch_last;
  logic mo_accept;
  logic m_hs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(C_NUM_MACS - 1)) ? '0 : p + PW'(1);
  endfunction

  // Outputs are also gated by ARESETN so they read 0 throughout reset,
  // not just after the first reset edge.
  assign s_ready       = ARESETN & (state_q == STREAM) & MAC_SD_TREADY[d_ptr_q];
  assign dispatch_hs   = s_ready & S_AXIS_TVALID;
  assign dispatch_last = dispatch_hs & S_AXIS_TLAST;
  // Accept only into an empty output buffer; this keeps MAC_MO_TREADY free of
  // any combinational path from M_AXIS_TREADY.
  assign mo_accept     = ARESETN & busy_q[c_ptr_q] & MAC_MO_TVALID[c_ptr_q] & ~out_valid_q;
  assign m_hs          = out_valid_q & M_AXIS_TREADY;

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TVALID = ARESETN & out_valid_q;
  assign M_AXIS_TDATA  = out_data_q;
  assign M_AXIS_TID    = out_tid_q;
  assign M_AXIS_TLAST  = 1'b1;
  assign OUTSTANDING   = outstanding_q;

  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_MACS; gi++) begin : g_lane
      assign MAC_SD_TVALID[gi] = ARESETN & (state_q == STREAM) &
                                 (d_ptr_q == PW'(gi)) & S_AXIS_TVALID;
      assign MAC_SD_TDATA[gi*2*C_DATA_WIDTH +: 2*C_DATA_WIDTH] = S_AXIS_TDATA;
      assign MAC_SD_TLAST[gi]          = S_AXIS_TLAST;
      assign MAC_SD_TUSER[gi*32 +: 32] = S_AXIS_TUSER;
      assign MAC_MO_TREADY[gi] = ARESETN & (c_ptr_q == PW'(gi)) & busy_q[gi] &
                                 MAC_MO_TVALID[gi] & ~out_valid_q;
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    d_ptr_d       = d_ptr_q;
    c_ptr_d       = c_ptr_q;
    busy_d        = busy_q;
    first_d       = first_q;
    tag_d         = tag_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_tid_d     = out_tid_q;
    outstanding_d = outstanding_q;

    case (state_q)
      IDLE: begin
        if (S_AXIS_TVALID) begin
          state_d = busy_q[d_ptr_q] ? WAIT_LANE : STREAM;
        end
      end
      WAIT_LANE: begin
        if (!busy_q[d_ptr_q]) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (dispatch_last) begin
          state_d         = IDLE;
          d_ptr_d         = ptr_inc(d_ptr_q);
          busy_d[d_ptr_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // first_q marks that the next accepted beat opens a packet.
    if (state_q != STREAM) begin
      first_d = 1'b1;
    end else if (dispatch_hs) begin
      first_d = 1'b0;
    end

    if (dispatch_hs && first_q) begin
      tag_d[d_ptr_q] = S_AXIS_TID;
    end

    // A dispatch sets busy on d_ptr (known idle) and an accept clears busy on
    // c_ptr (known busy), so the two never target the same lane.
    if (mo_accept) begin
      busy_d[c_ptr_q] = 1'b0;
      out_valid_d     = 1'b1;
      out_data_d      = MAC_MO_TDATA[c_ptr_q*32 +: 32];
      out_tid_d       = tag_q[c_ptr_q];
      c_ptr_d         = ptr_inc(c_ptr_q);
    end else if (m_hs) begin
      out_valid_d = 1'b0;
    end

    case ({dispatch_last, mo_accept})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q       <= IDLE;
      d_ptr_q       <= '0;
      c_ptr_q       <= '0;
      busy_q        <= '0;
      first_q       <= 1'b1;
      tag_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_tid_q     <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      d_ptr_q       <= d_ptr_d;
      c_ptr_q       <= c_ptr_d;
      busy_q        <= busy_d;
      first_q       <= first_d;
      tag_q         <= tag_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_tid_q     <= out_tid_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule
